uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_receiver_pkg.sv | 33 +++
 rtl/uart_rx_baud_gen.sv | 37 +++
 rtl/uart_receiver.sv | 140 ++++++++++++++
 tb/tb_uart_receiver.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_receiver_pkg.sv
// Shared types and constants for the UART receiver: FSM states and the
// baud-control decode to clk cycles per bit at 50 MHz.
package uart_receiver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam int DIV_W = 9;

    localparam logic [DIV_W-1:0] DIV_434 = 9'd434;
    localparam logic [DIV_W-1:0] DIV_217 = 9'd217;
    localparam logic [DIV_W-1:0] DIV_109 = 9'd109;
    localparam logic [DIV_W-1:0] DIV_72  = 9'd72;
    localparam logic [DIV_W-1:0] DIV_36  = 9'd36;

    function automatic logic [DIV_W-1:0] bc_to_div(input logic [2:0] bc);
        logic [DIV_W-1:0] div;
        case (bc)
            3'b001:  div = DIV_217;
            3'b010:  div = DIV_109;
            3'b011:  div = DIV_72;
            3'b100:  div = DIV_36;
            default: div = DIV_434;
        endcase
        return div;
    endfunction

endpackage

// File: rtl/uart_rx_baud_gen.sv
// Bit-period down-counter: emits a one-clk tick at each sample point, the
// first one half a period after half_start_i, then every full period.
module uart_rx_baud_gen
    import uart_receiver_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] divisor_i,
    input  logic             half_start_i,
    input  logic             run_i,
    output logic             tick_o
);

    localparam logic [DIV_W-1:0] ONE = 9'd1;

    logic [DIV_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (half_start_i) begin
            cnt_d = (divisor_i >> 1) - ONE;
        end else if (run_i) begin
            cnt_d = (cnt_q == '0) ? divisor_i - ONE : cnt_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: synchronizes Rx_in, frames start/data/parity/stop, loads
// DataOut on a good frame and pulses Mreset on a bad one.
//
// state     | meaning
// ST_IDLE   | waiting for a high-to-low edge on the synchronized line
// ST_START  | half a bit period in, confirming the start bit is still low
// ST_DATA   | shifting in D0..D7, one per bit period
// ST_PARITY | sampling the even-parity bit (only when latched PbitEna=1)
// ST_STOP   | sampling the stop bit and judging the frame
module uart_receiver
    import uart_receiver_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       Rx_in,
    input  logic       PbitEna,
    input  logic [2:0] BC,
    output logic [7:0] DataOut,
    output logic       Mreset,
    output logic       ena
);

    logic             sync1_q, sync2_q, rx_prev_q;
    rx_state_e        state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             pben_q, pben_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [7:0]       dout_q, dout_d;
    logic             mreset_q, mreset_d;
    logic             half_start, run, tick, rx_s, fall;

    assign rx_s = sync2_q;
    assign fall = rx_prev_q && !rx_s;
    assign run  = (state_q != ST_IDLE);

    // divisor is fed from div_d so the half-period load sees the fresh BC decode
    uart_rx_baud_gen u_baud (
        .clk          (clk),
        .reset        (reset),
        .divisor_i    (div_d),
        .half_start_i (half_start),
        .run_i        (run),
        .tick_o       (tick)
    );

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        pben_d     = pben_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        dout_d     = dout_q;
        mreset_d   = 1'b0;
        half_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d    = ST_START;
                    div_d      = bc_to_div(BC);
                    pben_d     = PbitEna;
                    half_start = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (!rx_s) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                        par_d     = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    par_d     = par_q ^ rx_s;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = pben_q ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    par_d   = par_q ^ rx_s;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    if (rx_s && !(pben_q && par_q)) begin
                        dout_d = shift_q;
                    end else begin
                        mreset_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= ST_IDLE;
            div_q     <= DIV_434;
            pben_q    <= 1'b0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            par_q     <= 1'b0;
            dout_q    <= 8'h00;
            mreset_q  <= 1'b0;
        end else begin
            sync1_q   <= Rx_in;
            sync2_q   <= sync1_q;
            rx_prev_q <= sync2_q;
            state_q   <= state_d;
            div_q     <= div_d;
            pben_q    <= pben_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            dout_q    <= dout_d;
            mreset_q  <= mreset_d;
        end
    end

    assign DataOut = dout_q;
    assign Mreset  = mreset_q;
    assign ena     = tick;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: frames are queued with their expected
// outcome when driven and checked by a monitor when DataOut/Mreset respond.
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       Rx_in = 1'b1;
    logic       PbitEna = 1'b0;
    logic [2:0] BC = 3'b000;
    logic [7:0] DataOut;
    logic       Mreset;
    logic       ena;

    uart_receiver dut (
        .clk     (clk),
        .reset   (reset),
        .Rx_in   (Rx_in),
        .PbitEna (PbitEna),
        .BC      (BC),
        .DataOut (DataOut),
        .Mreset  (Mreset),
        .ena     (ena)
    );

    always #10 clk = ~clk;

    typedef struct {
        bit         good;
        logic [7:0] dout;
        int         n_ena;
        int         n_div;
        int         ena_start;
        int         start_cyc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         ena_total = 0;
    int         last_ena = 0;
    int         ev_count = 0;
    int         mon_off;
    logic [7:0] last_dout = 8'h00;
    logic [7:0] model_dout = 8'h00;
    bit         prev_mreset = 1'b0;

    function automatic int div_of(input logic [2:0] bc);
        case (bc)
            3'b001:  return 217;
            3'b010:  return 109;
            3'b011:  return 72;
            3'b100:  return 36;
            default: return 434;
        endcase
    endfunction

    // Monitor: ena spacing, Mreset width, and frame outcome vs. scoreboard
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (reset !== 1'b1) begin
            last_dout   = DataOut;
            prev_mreset = 1'b0;
        end else begin
            if (ena === 1'b1) begin
                if (exp_q.size() > 0) begin
                    total++;
                    if (ena_total == exp_q[0].ena_start) begin
                        mon_off = cyc - exp_q[0].start_cyc;
                        if (mon_off < exp_q[0].n_div / 2 + 2 || mon_off > exp_q[0].n_div / 2 + 4) begin
                            bad++;
                            $display("FAIL start_sample_offset got=%0d want=%0d(+-1)", mon_off, exp_q[0].n_div / 2 + 3);
                        end
                    end else if (cyc - last_ena != exp_q[0].n_div) begin
                        bad++;
                        $display("FAIL ena_spacing got=%0d want=%0d", cyc - last_ena, exp_q[0].n_div);
                    end
                end
                ena_total++;
                last_ena = cyc;
            end
            if (prev_mreset) begin
                total++;
                if (Mreset !== 1'b0) begin
                    bad++;
                    $display("FAIL mreset_width got=%b want=0 on second clk", Mreset);
                end
            end
            if ((Mreset === 1'b1 && !prev_mreset) || DataOut !== last_dout) begin
                ev_count++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_output dout=%0h mreset=%b want=no event", DataOut, Mreset);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ((Mreset !== 1'b1) != mon_e.good) begin
                        bad++;
                        $display("FAIL frame_good got=%b want=%b", Mreset !== 1'b1, mon_e.good);
                    end
                    total++;
                    if (DataOut !== mon_e.dout) begin
                        bad++;
                        $display("FAIL dataout got=%0h want=%0h", DataOut, mon_e.dout);
                    end
                    total++;
                    if (ena_total - mon_e.ena_start != mon_e.n_ena) begin
                        bad++;
                        $display("FAIL ena_count got=%0d want=%0d", ena_total - mon_e.ena_start, mon_e.n_ena);
                    end
                    total++;
                    if (cyc != last_ena + 1) begin
                        bad++;
                        $display("FAIL result_latency got=%0d want=1", cyc - last_ena);
                    end
                end
                last_dout = DataOut;
            end
            prev_mreset = (Mreset === 1'b1);
        end
    end

    task automatic hold_bit(input logic v, input int n);
        Rx_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1. Pushes the expected outcome, then drives the frame.
    task automatic send_frame(input logic [2:0] bc, input bit pen, input logic [7:0] data,
                              input bit par_bad, input bit stop, input int low_hold, input int idle_after);
        exp_t e;
        int   n;
        int   ev0;
        int   e0;
        logic par;
        n           = div_of(bc);
        par         = (^data) ^ par_bad;
        e.good      = stop && !(pen && par_bad);
        e.dout      = e.good ? data : model_dout;
        model_dout  = e.dout;
        e.n_ena     = pen ? 11 : 10;
        e.n_div     = n;
        e.ena_start = ena_total;
        e.start_cyc = cyc;
        ev0         = ev_count;
        BC          = bc;
        PbitEna     = pen;
        exp_q.push_back(e);
        hold_bit(1'b0, n);
        BC      = ~bc;
        PbitEna = ~pen;
        for (int i = 0; i < 8; i++) hold_bit(data[i], n);
        if (pen) hold_bit(par, n);
        hold_bit(stop, n);
        if (low_hold > 0 && !stop) begin
            e0 = ena_total;
            repeat (low_hold) @(posedge clk);
            #1;
            total++;
            if (ena_total != e0) begin
                bad++;
                $display("FAIL low_line_restart got=%0d want=0 extra ena", ena_total - e0);
            end
        end
        for (int k = 0; k < n && ev_count == ev0; k++) @(posedge clk);
        #1;
        total++;
        if (ev_count == ev0) begin
            bad++;
            $display("FAIL frame_timeout got=no result want=result for %0h", data);
        end
        Rx_in = 1'b1;
        repeat (idle_after) @(posedge clk);
        #1;
        total++;
        if (DataOut !== model_dout) begin
            bad++;
            $display("FAIL dataout_after_frame got=%0h want=%0h", DataOut, model_dout);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        Rx_in = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        total++;
        if (DataOut !== 8'h00) begin bad++; $display("FAIL reset_dataout got=%0h want=00", DataOut); end
        total++;
        if (Mreset !== 1'b0) begin bad++; $display("FAIL reset_mreset got=%b want=0", Mreset); end
        total++;
        if (ena !== 1'b0) begin bad++; $display("FAIL reset_ena got=%b want=0", ena); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        total++;
        if (ena_total != 0) begin bad++; $display("FAIL idle_ena got=%0d want=0", ena_total); end
    endtask

    task automatic test_parity_frames();
        send_frame(3'b000, 1'b1, 8'h85, 1'b0, 1'b1, 0, 50);
        send_frame(3'b100, 1'b1, 8'hCF, 1'b0, 1'b1, 0, 20);
        send_frame(3'b100, 1'b1, 8'h47, 1'b1, 1'b1, 0, 20);
    endtask

    task automatic test_stop_error();
        send_frame(3'b011, 1'b0, 8'h1F, 1'b0, 1'b0, 3 * 72, 20);
        send_frame(3'b011, 1'b0, 8'h1F, 1'b0, 1'b1, 0, 20);
    endtask

    task automatic test_back_to_back();
        send_frame(3'b010, 1'b0, 8'h3C, 1'b0, 1'b1, 0, 0);
        send_frame(3'b010, 1'b1, 8'hC3, 1'b0, 1'b1, 0, 0);
        send_frame(3'b001, 1'b1, 8'h5A, 1'b0, 1'b1, 0, 30);
        send_frame(3'b110, 1'b0, 8'h66, 1'b0, 1'b1, 0, 30);
    endtask

    task automatic test_glitch();
        int e0;
        int ev0;
        BC  = 3'b000;
        e0  = ena_total;
        ev0 = ev_count;
        Rx_in = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        Rx_in = 1'b1;
        repeat (1000) @(posedge clk);
        #1;
        total++;
        if (ena_total - e0 != 1) begin bad++; $display("FAIL glitch_ena got=%0d want=1", ena_total - e0); end
        total++;
        if (ev_count != ev0) begin bad++; $display("FAIL glitch_event got=%0d want=0", ev_count - ev0); end
        total++;
        if (DataOut !== model_dout) begin bad++; $display("FAIL glitch_dataout got=%0h want=%0h", DataOut, model_dout); end
    endtask

    task automatic test_reset_midframe();
        int   n;
        int   ev0;
        logic [7:0] d;
        n   = 36;
        d   = 8'hF0;
        ev0 = ev_count;
        BC      = 3'b100;
        PbitEna = 1'b1;
        hold_bit(1'b0, n);
        for (int i = 0; i < 4; i++) hold_bit(d[i], n);
        hold_bit(d[4], n / 2);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (DataOut !== 8'h00) begin bad++; $display("FAIL midreset_dataout got=%0h want=00", DataOut); end
        total++;
        if (ena !== 1'b0 || Mreset !== 1'b0) begin
            bad++;
            $display("FAIL midreset_outputs got=ena%b/mreset%b want=0/0", ena, Mreset);
        end
        @(posedge clk);
        #1;
        Rx_in      = 1'b1;
        reset      = 1'b1;
        model_dout = 8'h00;
        repeat (12 * n) @(posedge clk);
        #1;
        total++;
        if (ev_count != ev0 || DataOut !== 8'h00) begin
            bad++;
            $display("FAIL abort_quiet got=%0h/%0d events want=00/0", DataOut, ev_count - ev0);
        end
        send_frame(3'b100, 1'b1, 8'hA5, 1'b0, 1'b1, 0, 20);
    endtask

    initial begin
        test_reset();
        test_parity_frames();
        test_stop_error();
        test_back_to_back();
        test_glitch();
        test_reset_midframe();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL pending_frames got=%0d want=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout want=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
